// File: rtl/writeback_arbiter_pkg.sv
// Shared types for the register-file writeback path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: data/index widths, grant encoding, {rd,data} writeback request record.
package writeback_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_ALU,
    GNT_FIFO
  } grant_e;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Bundle of the writeback arbiter's handshake, scoreboard and register-file signals.
// Latency: n/a (wiring only).
// Backpressure: alu_ready / lu_ready are driven by the arbiter (slave side).
// Ports: alu_* and lu_* result channels, rs1/rs2 scoreboard lookup with busy flags,
//        Reg_write / Write_reg_num / Write_data register file write port.
interface writeback_arbiter_if;
  import writeback_arbiter_pkg::*;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              lu_valid;
  logic [ADDR_W-1:0] lu_rd;
  logic [DATA_W-1:0] lu_data;
  logic              lu_ready;

  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic              rs1_busy;
  logic              rs2_busy;

  logic              Reg_write;
  logic [ADDR_W-1:0] Write_reg_num;
  logic [DATA_W-1:0] Write_data;

  // Producer / decode / register-file side.
  modport master (
    output alu_valid, alu_rd, alu_data, lu_valid, lu_rd, lu_data, rs1, rs2,
    input  alu_ready, lu_ready, rs1_busy, rs2_busy, Reg_write, Write_reg_num, Write_data
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_rd, alu_data, lu_valid, lu_rd, lu_data, rs1, rs2,
    output alu_ready, lu_ready, rs1_busy, rs2_busy, Reg_write, Write_reg_num, Write_data
  );

endinterface

// File: rtl/writeback_arbiter_wb_fifo.sv
// Small FIFO of pending long-latency writebacks with per-entry destination match for the scoreboard.
// Latency: entry pushed at edge N is visible at the head from the cycle after edge N (no bypass).
// Backpressure: full asserted at DEPTH entries; pushes while full and pops while empty are ignored.
// Ports: clk/reset, push_vld/push_dat, pop_vld, head_dat, full/empty, rs1/rs2 -> rs1_match/rs2_match.
module writeback_arbiter_wb_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_vld,
  input  wb_req_t           push_dat,
  input  logic              pop_vld,
  output wb_req_t           head_dat,
  output logic              full,
  output logic              empty,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic [DEPTH-1:0]  rs1_match,
  output logic [DEPTH-1:0]  rs2_match
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_req_t            mem [DEPTH];
  logic [DEPTH-1:0]   ent_vld;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push_ok;
  logic               pop_ok;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push_vld && !full;
  assign pop_ok   = pop_vld && !empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr          <= wr_ptr + PTR_W'(1);
        ent_vld[wr_ptr] <= 1'b1;
      end
      // wr_ptr==rd_ptr only when empty (no pop) or full (no push), so these never collide.
      if (pop_ok) begin
        rd_ptr          <= rd_ptr + PTR_W'(1);
        ent_vld[rd_ptr] <= 1'b0;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: ent_vld qualifies every read that matters.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // ent_vld tracks exactly the occupied slots between rd_ptr and wr_ptr, wrap included.
  always_comb begin
    rs1_match = '0;
    rs2_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rs1_match[i] = ent_vld[i] && (mem[i].rd == rs1);
      rs2_match[i] = ent_vld[i] && (mem[i].rd == rs2);
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write master: merges ALU and buffered long-latency results into one write port.
// Latency: ALU 1 cycle to Reg_write; long-latency at least 2 cycles (push, then pop/write).
// Backpressure: alu_ready drops only on a FIFO grant; lu_ready drops while the FIFO is full.
// Ports: clk, reset (async active-low), bus (writeback_arbiter_if.slave).
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  writeback_arbiter_if.slave   bus
);

  localparam int STV_W = $clog2(STARVE_MAX + 1);

  grant_e             grant;
  wb_req_t            alu_req;
  wb_req_t            lu_req;
  wb_req_t            head_dat;
  wb_req_t            win_req;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_force;
  logic               push_vld;
  logic               pop_vld;
  logic [DEPTH-1:0]   rs1_match;
  logic [DEPTH-1:0]   rs2_match;
  logic [STV_W-1:0]   starve;

  logic               reg_write_q;
  logic [ADDR_W-1:0]  write_reg_num_q;
  logic [DATA_W-1:0]  write_data_q;

  assign alu_req = '{rd: bus.alu_rd, data: bus.alu_data};
  assign lu_req  = '{rd: bus.lu_rd,  data: bus.lu_data};

  assign push_vld = bus.lu_valid && !fifo_full;
  assign pop_vld  = (grant == GNT_FIFO);

  writeback_arbiter_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_vld  (push_vld),
    .push_dat  (lu_req),
    .pop_vld   (pop_vld),
    .head_dat  (head_dat),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .rs1       (bus.rs1),
    .rs2       (bus.rs2),
    .rs1_match (rs1_match),
    .rs2_match (rs2_match)
  );

  // A full FIFO, or a pending head that has lost STARVE_MAX times in a row, pre-empts the ALU.
  assign fifo_force = fifo_full || ((starve == STV_W'(STARVE_MAX)) && !fifo_empty);

  always_comb begin
    grant = GNT_NONE;
    if (fifo_force) begin
      grant = GNT_FIFO;
    end else if (bus.alu_valid) begin
      grant = GNT_ALU;
    end else if (!fifo_empty) begin
      grant = GNT_FIFO;
    end
  end

  assign win_req = (grant == GNT_FIFO) ? head_dat : alu_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve <= '0;
    end else if ((grant == GNT_FIFO) || fifo_empty) begin
      starve <= '0;
    end else if ((grant == GNT_ALU) && (starve != STV_W'(STARVE_MAX))) begin
      starve <= starve + STV_W'(1);
    end
  end

  // Index/data hold while idle: the register file reacts to changes on them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write_q     <= 1'b0;
      write_reg_num_q <= '0;
      write_data_q    <= '0;
    end else if (grant != GNT_NONE) begin
      reg_write_q     <= (win_req.rd != '0);
      write_reg_num_q <= win_req.rd;
      write_data_q    <= win_req.data;
    end else begin
      reg_write_q     <= 1'b0;
    end
  end

  assign bus.alu_ready     = (grant != GNT_FIFO);
  assign bus.lu_ready      = !fifo_full;
  assign bus.rs1_busy      = (bus.rs1 != '0) && (|rs1_match);
  assign bus.rs2_busy      = (bus.rs2 != '0) && (|rs2_match);
  assign bus.Reg_write     = reg_write_q;
  assign bus.Write_reg_num = write_reg_num_q;
  assign bus.Write_data    = write_data_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: per-cycle vector table plus reset and wrap sequences.
module tb_writeback_arbiter;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  writeback_arbiter_if bus ();

  writeback_arbiter #(
    .DEPTH      (4),
    .STARVE_MAX (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_ar;
    logic        e_lr;
    logic        e_b1;
    logic        e_b2;
    logic        e_we;
    logic [4:0]  e_num;
    logic [31:0] e_dat;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  function automatic vec_t mk(logic av, logic [4:0] ard, logic [31:0] ad,
                              logic lv, logic [4:0] lrd, logic [31:0] ld,
                              logic [4:0] r1, logic [4:0] r2,
                              logic ear, logic elr, logic eb1, logic eb2,
                              logic ewe, logic [4:0] en, logic [31:0] edat);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad;
    v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.r1 = r1; v.r2 = r2;
    v.e_ar = ear; v.e_lr = elr; v.e_b1 = eb1; v.e_b2 = eb2;
    v.e_we = ewe; v.e_num = en; v.e_dat = edat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic [4:0] r1, input logic [4:0] r2);
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = ad;
    bus.lu_valid  = lv;
    bus.lu_rd     = lrd;
    bus.lu_data   = ld;
    bus.rs1       = r1;
    bus.rs2       = r2;
  endtask

  logic [4:0]  got_num [$];
  logic [31:0] got_dat [$];

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    //          av ard  ad            lv lrd ld        r1 r2  ar lr b1 b2  we num dat
    tbl[0]  = mk(0, 0,  32'h0,        0, 0, 32'h0,     0, 0,  1, 1, 0, 0,  0, 0,  32'h0);
    tbl[1]  = mk(1, 5,  32'hDEADBEEF, 0, 0, 32'h0,     0, 0,  1, 1, 0, 0,  1, 5,  32'hDEADBEEF);
    tbl[2]  = mk(0, 0,  32'h0,        0, 0, 32'h0,     0, 0,  1, 1, 0, 0,  0, 5,  32'hDEADBEEF);
    // fill the FIFO with rd=1..4 while the ALU keeps winning
    tbl[3]  = mk(1, 10, 32'hA0,       1, 1, 32'h11,    3, 1,  1, 1, 0, 0,  1, 10, 32'hA0);
    tbl[4]  = mk(1, 11, 32'hA1,       1, 2, 32'h22,    3, 1,  1, 1, 0, 1,  1, 11, 32'hA1);
    tbl[5]  = mk(1, 12, 32'hA2,       1, 3, 32'h33,    3, 1,  1, 1, 0, 1,  1, 12, 32'hA2);
    tbl[6]  = mk(1, 13, 32'hA3,       1, 4, 32'h44,    3, 1,  1, 1, 1, 1,  1, 13, 32'hA3);
    tbl[7]  = mk(1, 14, 32'hA4,       1, 5, 32'h55,    3, 1,  0, 0, 1, 1,  1, 1,  32'h11);
    tbl[8]  = mk(1, 14, 32'hA4,       0, 0, 32'h0,     3, 1,  1, 1, 1, 0,  1, 14, 32'hA4);
    tbl[9]  = mk(0, 0,  32'h0,        0, 0, 32'h0,     3, 1,  0, 1, 1, 0,  1, 2,  32'h22);
    tbl[10] = mk(0, 0,  32'h0,        0, 0, 32'h0,     3, 1,  0, 1, 1, 0,  1, 3,  32'h33);
    tbl[11] = mk(0, 0,  32'h0,        0, 0, 32'h0,     3, 4,  0, 1, 0, 1,  1, 4,  32'h44);
    tbl[12] = mk(0, 0,  32'h0,        0, 0, 32'h0,     3, 4,  1, 1, 0, 0,  0, 4,  32'h44);
    // x0 on both paths
    tbl[13] = mk(1, 0,  32'h1234,     1, 0, 32'h5678,  0, 0,  1, 1, 0, 0,  0, 0,  32'h1234);
    tbl[14] = mk(0, 0,  32'h0,        0, 0, 32'h0,     0, 0,  0, 1, 0, 0,  0, 0,  32'h5678);
    tbl[15] = mk(0, 0,  32'h0,        0, 0, 32'h0,     0, 0,  1, 1, 0, 0,  0, 0,  32'h5678);
    // starvation: rd=7 buffered, ALU wins three times, then forced through
    tbl[16] = mk(1, 20, 32'hB0,       1, 7, 32'h77,    7, 0,  1, 1, 0, 0,  1, 20, 32'hB0);
    tbl[17] = mk(1, 21, 32'hB1,       0, 0, 32'h0,     7, 0,  1, 1, 1, 0,  1, 21, 32'hB1);
    tbl[18] = mk(1, 22, 32'hB2,       0, 0, 32'h0,     7, 0,  1, 1, 1, 0,  1, 22, 32'hB2);
    tbl[19] = mk(1, 23, 32'hB3,       0, 0, 32'h0,     7, 0,  1, 1, 1, 0,  1, 23, 32'hB3);
    tbl[20] = mk(1, 24, 32'hB4,       0, 0, 32'h0,     7, 0,  0, 1, 1, 0,  1, 7,  32'h77);
    tbl[21] = mk(1, 24, 32'hB4,       0, 0, 32'h0,     7, 0,  1, 1, 0, 0,  1, 24, 32'hB4);
    tbl[22] = mk(0, 0,  32'h0,        0, 0, 32'h0,     7, 0,  1, 1, 0, 0,  0, 24, 32'hB4);

    // power-on reset state
    repeat (2) @(posedge clk);
    #1;
    chk("por_reg_write", bus.Reg_write, 0);
    chk("por_reg_num", bus.Write_reg_num, 0);
    chk("por_data", bus.Write_data, 0);
    chk("por_lu_ready", bus.lu_ready, 1);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].lv, tbl[i].lrd, tbl[i].ld, tbl[i].r1, tbl[i].r2);
      #1;
      chk($sformatf("v%0d_alu_ready", i), bus.alu_ready, tbl[i].e_ar);
      chk($sformatf("v%0d_lu_ready", i), bus.lu_ready, tbl[i].e_lr);
      chk($sformatf("v%0d_rs1_busy", i), bus.rs1_busy, tbl[i].e_b1);
      chk($sformatf("v%0d_rs2_busy", i), bus.rs2_busy, tbl[i].e_b2);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_reg_write", i), bus.Reg_write, tbl[i].e_we);
      chk($sformatf("v%0d_reg_num", i), bus.Write_reg_num, tbl[i].e_num);
      chk($sformatf("v%0d_data", i), bus.Write_data, tbl[i].e_dat);
    end

    // Push/pop at constant occupancy 2 across pointer wrap: retire order must be rd=1..10.
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c < 2)
        drive(1, 0, 32'h0, 1, 5'(c + 1), 32'((c + 1) * 256), 0, 0);
      else if (c < 10)
        drive(0, 0, 32'h0, 1, 5'(c + 1), 32'((c + 1) * 256), 0, 0);
      else
        drive(0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
      #1;
      if (c < 10) chk($sformatf("wrap_c%0d_lu_ready", c), bus.lu_ready, 1);
      @(posedge clk);
      #1;
      if (bus.Reg_write) begin
        got_num.push_back(bus.Write_reg_num);
        got_dat.push_back(bus.Write_data);
      end
    end
    chk("wrap_write_count", got_num.size(), 10);
    for (int k = 0; k < 10; k++) begin
      if (k < got_num.size()) begin
        chk($sformatf("wrap_w%0d_num", k), got_num[k], k + 1);
        chk($sformatf("wrap_w%0d_data", k), got_dat[k], (k + 1) * 256);
      end
    end

    // Mid-stream asynchronous reset.
    @(negedge clk);
    drive(1, 9, 32'h99, 1, 3, 32'h33, 3, 0);
    @(posedge clk);
    #1;
    chk("rst_pre_reg_write", bus.Reg_write, 1);
    chk("rst_pre_reg_num", bus.Write_reg_num, 9);
    @(negedge clk);
    drive(1, 8, 32'h88, 1, 6, 32'h66, 3, 0);
    #1;
    chk("rst_pre_rs1_busy", bus.rs1_busy, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_async_reg_write", bus.Reg_write, 0);
    chk("rst_async_reg_num", bus.Write_reg_num, 0);
    chk("rst_async_data", bus.Write_data, 0);
    chk("rst_async_lu_ready", bus.lu_ready, 1);
    chk("rst_async_rs1_busy", bus.rs1_busy, 0);
    @(posedge clk);
    #1;
    chk("rst_held_reg_write", bus.Reg_write, 0);
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 0, 32'h0, 3, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_release_reg_write", bus.Reg_write, 0);
    chk("rst_release_reg_num", bus.Write_reg_num, 0);
    @(negedge clk);
    #1;
    chk("rst_after_alu_ready", bus.alu_ready, 1);
    chk("rst_after_rs1_busy", bus.rs1_busy, 0);
    @(posedge clk);
    #1;
    chk("rst_after_reg_write", bus.Reg_write, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
